// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
// The window has two words: TXDATA at BASE_ADDR (write pushes a byte) and
// STATUS at BASE_ADDR+4 (read status; writing bit3=1 clears overflow).
// Ports:
//   CLK     system clock, rising edge
//   RES     asynchronous active-high reset
//   read    bus read strobe
//   write   bus write strobe
//   addr    bus byte address
//   dataIn  bus write data
//   dataOut STATUS read data, 0 when not reading STATUS
//   hit     addr falls inside the register window (combinational)
//   txd     serial output, idle high
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        hit,
  output logic        txd
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q;
  logic [BW-1:0]        baud_q;
  logic [2:0]           bit_q;
  logic [7:0]           sh_q;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 ovf_q;

  logic                 push_req, push_ok, pop, clr_ovf, full, empty, busy;
  logic [31:0]          count_ext;
  logic [3:0]           count_field;
  logic [31:0]          status;
  logic                 unused_data;

  assign hit      = (addr[31:3] == BASE_ADDR[31:3]) && (addr[1:0] == 2'b00);
  assign push_req = write && hit && !addr[2];
  assign clr_ovf  = write && hit && addr[2] && dataIn[3];
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != StIdle);
  assign pop      = (state_q == StIdle) && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
  assign push_ok  = push_req && (!full || pop);

  assign unused_data = ^dataIn[31:8];

  // Count field is 4 bits wide; saturate if the FIFO count is wider.
  assign count_ext   = 32'(count_q);
  assign count_field = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  always_comb begin
    status      = '0;
    status[0]   = full;
    status[1]   = empty;
    status[2]   = busy;
    status[3]   = ovf_q;
    status[7:4] = count_field;
  end

  assign dataOut = (read && hit && addr[2]) ? status : 32'h0;

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr_q] <= dataIn[7:0];
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // Set has priority over a same-cycle clear.
      if (push_req && !push_ok) ovf_q <= 1'b1;
      else if (clr_ovf)         ovf_q <= 1'b0;
    end
  end

  // txd is registered from the current state, so the line lags the state by one
  // cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd     <= 1'b1;
    end else begin
      case (state_q)
        StIdle:  txd <= 1'b1;
        StStart: txd <= 1'b0;
        StData:  txd <= sh_q[0];
        default: txd <= 1'b1;
      endcase

      case (state_q)
        StIdle: begin
          if (pop) begin
            sh_q    <= mem[rd_ptr_q];
            bit_q   <= '0;
            baud_q  <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= StData;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        StData: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            sh_q   <= {1'b0, sh_q[7:1]};
            if (bit_q == 3'd7) state_q <= StStop;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= StIdle;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO depth 8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        CLK, RES, read, write, hit, txd;
  logic [31:0] addr, dataIn, dataOut;

  int total = 0;
  int bad   = 0;

  logic [127:0] v;
  logic [31:0]  st;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(4),
    .FIFO_AW     (3)
  ) dut (
    .CLK    (CLK),
    .RES    (RES),
    .read   (read),
    .write  (write),
    .addr   (addr),
    .dataIn (dataIn),
    .dataOut(dataOut),
    .hit    (hit),
    .txd    (txd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; the write lands on the next rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    dataIn = d;
    write  = 1'b1;
    @(negedge CLK);
    write  = 1'b0;
    addr   = '0;
    dataIn = '0;
  endtask

  task automatic read_status(output logic [31:0] s);
    addr = BASE + 32'd4;
    read = 1'b1;
    #1 s = dataOut;
    read = 1'b0;
    addr = '0;
  endtask

  // Samples txd n times, one per falling edge; first sample ends up most significant.
  task automatic capture(input int n, output logic [127:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = {r[126:0], txd};
      @(negedge CLK);
    end
  endtask

  initial begin
    RES = 1'b1; read = 1'b0; write = 1'b0; addr = '0; dataIn = '0;
    repeat (3) @(negedge CLK);
    RES = 1'b0;
    check("rst_txd", 128'(txd), 128'(1'b1));
    check("rst_hit", 128'(hit), 128'(1'b0));
    read_status(st);
    check("rst_status", 128'(st), 128'(32'h2));

    // Single byte 0x55: line falls two edges after the write edge.
    bus_write(BASE, 32'hABCD_0055);
    read_status(st);
    check("st_queued", 128'(st), 128'(32'h10));
    @(negedge CLK);
    read_status(st);
    check("st_popped", 128'(st), 128'(32'h6));
    check("txd_before_start", 128'(txd), 128'(1'b1));
    @(negedge CLK);
    capture(40, v);
    check("frame_55", v, 128'(40'h0F0F0F0F0F));
    read_status(st);
    check("st_after_frame", 128'(st), 128'(32'h2));

    // Back-to-back 0x00 then 0xFF: stop bit plus one idle cycle between frames.
    bus_write(BASE, 32'h0000_0000);
    bus_write(BASE, 32'h0000_00FF);
    @(negedge CLK);
    capture(81, v);
    check("b2b_frame0", 128'(v[80:41]), 128'(40'h000000000F));
    check("b2b_gap", 128'(v[40]), 128'(1'b1));
    check("b2b_frameFF", 128'(v[39:0]), 128'(40'h0FFFFFFFFF));
    repeat (3) @(negedge CLK);

    // Fill: 10 writes -> one popped, eight queued, one dropped.
    for (int i = 0; i < 10; i++) bus_write(BASE, 32'h10 + 32'(i));
    read_status(st);
    check("st_full_ovf", 128'(st), 128'(32'h8D));
    bus_write(BASE + 32'd4, 32'h8);
    read_status(st);
    check("st_ovf_clr", 128'(st), 128'(32'h85));

    // First frame started at edge 1, FSM is idle after edge 41, pops at edge 42.
    repeat (31) @(negedge CLK);
    read_status(st);
    check("st_idle_full", 128'(st), 128'(32'h81));
    bus_write(BASE, 32'h77);
    read_status(st);
    check("st_push_pop_full", 128'(st), 128'(32'h85));
    @(negedge CLK);
    capture(40, v);
    check("frame_11", v, 128'(40'h0F000F000F));

    // Byte 0x12 is now sending; 18 falling edges lands inside data bit 3 (a 0).
    repeat (18) @(negedge CLK);
    check("txd_bit3", 128'(txd), 128'(1'b0));
    #2 RES = 1'b1;
    #1;
    check("txd_async_rst", 128'(txd), 128'(1'b1));
    read_status(st);
    check("st_in_rst", 128'(st), 128'(32'h2));
    repeat (2) @(negedge CLK);
    RES = 1'b0;
    capture(50, v);
    check("no_residual", 128'(v[49:0]), 128'({50{1'b1}}));
    read_status(st);
    check("st_after_rst", 128'(st), 128'(32'h2));

    // Decode: misaligned / outside the window must not hit or push.
    addr = BASE + 32'd8; dataIn = 32'h33; write = 1'b1;
    #1 check("hit_base8", 128'(hit), 128'(1'b0));
    @(negedge CLK);
    write = 1'b0;
    addr = BASE + 32'd1; write = 1'b1;
    #1 check("hit_base1", 128'(hit), 128'(1'b0));
    @(negedge CLK);
    write = 1'b0; addr = '0;
    read_status(st);
    check("st_no_push", 128'(st), 128'(32'h2));
    addr = BASE + 32'd4; read = 1'b0;
    #1 check("hit_status", 128'(hit), 128'(1'b1));
    check("noread_zero", 128'(dataOut), 128'(32'h0));
    addr = BASE; read = 1'b1;
    #1 check("txdata_read_zero", 128'(dataOut), 128'(32'h0));
    check("hit_txdata", 128'(hit), 128'(1'b1));
    read = 1'b0; addr = '0;
    @(negedge CLK);
    capture(8, v);
    check("idle_line", 128'(v[7:0]), 128'(8'hFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the core's data bus, beside the main memory. Decodes bus writes to its register window and queues bytes in an internal FIFO. Serializes bytes 8N1 on txd. Returns a select flag so the top level can mux its read data against memory read data.

Parameters:
BASE_ADDR, 32'hFFFF_0000, word-aligned base of the 2-register window
CLKS_PER_BIT, 868, CLK cycles per serial bit (>=2)
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW

Ports:
CLK  input  1  system clock, rising edge
RES  input  1  asynchronous active-high reset
read  input  1  bus read strobe
write  input  1  bus write strobe
addr  input  32  bus byte address
dataIn  input  32  bus write data
dataOut  output  32  register read data
hit  output  1  addr is inside the window (BASE_ADDR or BASE_ADDR+4)
txd  output  1  serial output, idle high

Behaviour:
- One clock (CLK). RES is asynchronous and active-high; it clears all state immediately, regardless of CLK.
- Reset values: txd=1, FSM=IDLE, FIFO empty (wr_ptr=rd_ptr=count=0), overflow=0, dataOut=0, hit=0 when addr is outside the window.
- Decode: hit = (addr[31:3]==BASE_ADDR[31:3]) && (addr[1:0]==0); it is combinational. addr[2]=0 selects TXDATA and addr[2]=1 selects STATUS.
- TXDATA write (write && hit && !addr[2]): push dataIn[7:0] at the CLK edge. The upper 24 bits are ignored.
- STATUS layout: bit0 full, bit1 empty, bit2 busy (FSM!=IDLE), bit3 overflow, bits[7:4] count (zero-extended; FIFO_AW+1 bits, saturating the field if wider), bits[31:8]=0.
- STATUS write with dataIn[3]=1 clears overflow. Other bits are read-only.
- Reads are combinational: dataOut = STATUS if (read && hit && addr[2]), else 0. A TXDATA read returns 0. Reads have no side effects.
- Push rule: the push is accepted if count<depth, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - If overflow is set and cleared in the same cycle, set wins.
- Simultaneous push+pop leaves count unchanged. Pointers wrap modulo depth.
- FIFO storage is a register array. Full is count==depth; empty is count==0.
- FSM states and transitions:
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into shift register sh[7:0], load the bit counter to 0 and the baud counter to 0, and go to START. The pop occurs on that edge.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: txd=sh[0]; every CLKS_PER_BIT cycles shift right and increment the bit index; after bit 7, go to STOP. LSB is sent first.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
- txd is registered, driven from the state and sh.
- The baud counter runs 0..CLKS_PER_BIT-1. Each bit lasts exactly CLKS_PER_BIT cycles, and the frame is 10*CLKS_PER_BIT cycles.
- Back-to-back timing: STOP→IDLE→START costs one IDLE cycle. The inter-frame gap is therefore 1 cycle of txd=1 beyond the stop bit.
- A push while the FIFO is empty and the FSM is IDLE is popped on the next edge. First start bit: txd falls 2 edges after the write edge.
- RES mid-frame: txd returns to 1 immediately, the FIFO is flushed, and there is no partial-byte completion.
- The read and write strobes are never both asserted. If both are asserted, the write takes effect and dataOut follows the read rule.

Test Plan:
- Reset (CLKS_PER_BIT=4): assert RES asynchronously mid-cycle -> txd=1 at once; STATUS read = 32'h0000_0002 (empty).
- Single byte: write 32'hABCD_0055 to BASE_ADDR, then idle -> txd frame 0,1,0,1,0,1,0,1,0,1 (start, LSB-first 0x55, stop), each bit 4 cycles. busy=1 during the frame and 0 after.
- Fill/overflow (CLKS_PER_BIT=1000, FIFO_AW=3): write 10 bytes back-to-back -> first byte popped, 8 queued. STATUS: full=1, count=8, overflow=1. Write STATUS with 0x8 -> overflow=0.
- Back-to-back frames: push 0x00 and 0xFF -> frames are contiguous, separated by exactly stop bit plus 1 idle cycle. Received bytes are 0x00 then 0xFF, in order.
- Push+pop while full: with the FIFO full, write a byte on the exact cycle the FSM pops -> accepted, count stays 8, overflow stays 0.
- Decode: write to BASE_ADDR+8 and to BASE_ADDR+1 -> hit=0, no push. Read BASE_ADDR+4 with read=0 -> dataOut=0.
- RES during DATA bit 3 -> txd=1 immediately; after release the FIFO is empty and no residual frame is sent.
